sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Input conditioning stage between the Nexys4 slide switches and the switch-driven state machine top level.
- Each raw asynchronous SW bit passes through a 2-flop synchronizer and then a per-channel stability counter.
- Produces clean debounced levels that drive the state machine's SW inputs, plus optional one-cycle edge strobes.

Parameters:
- WIDTH, 5, number of switch channels.
- DB_CYCLES, 1000000, consecutive stable clock cycles required to accept a new level (10 ms at 100 MHz); legal range 2..2^CNT_W.
- CNT_W, 20, width of each per-channel stability counter.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz board oscillator; all logic on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- SW  input  WIDTH  raw switch levels, asynchronous to CLK100MHZ.
- SW_DB  output  WIDTH  debounced switch levels.
- SW_RISE  output  WIDTH  one-cycle pulse per bit when SW_DB goes 0->1.
- SW_FALL  output  WIDTH  one-cycle pulse per bit when SW_DB goes 1->0.
- SW_CHG  output  1  one-cycle pulse when any SW_DB bit changes.

Behaviour:
- Reset: RST high clears asynchronously s1, s2, SW_DB, all counters, SW_RISE, SW_FALL and SW_CHG to 0. All channels enter state IDLE.
- Synchronizer: s1 <= SW and s2 <= s1 on every edge. No logic sits between s1 and s2.
- Per-channel FSM, two states:
  - IDLE: s2 == SW_DB; cnt held at 0. If s2 != SW_DB, go to PEND with cnt <= 1.
  - PEND, while s2 != SW_DB:
    - if cnt == DB_CYCLES-1: SW_DB <= s2, cnt <= 0, go to IDLE;
    - else cnt <= cnt+1.
  - PEND, if s2 == SW_DB (bounce back): cnt <= 0, go to IDLE, SW_DB unchanged.
- Latency: a level change on SW set up before edge k appears on s2 after edge k+1. SW_DB updates on edge k+1+DB_CYCLES, provided s2 holds the new value for DB_CYCLES consecutive edges.
- Boundary conditions:
  - Any single-cycle return to the old level restarts the count from zero.
  - Glitches shorter than DB_CYCLES never reach SW_DB.
- Channels are fully independent; simultaneous changes on several bits are each debounced on their own counter.
- Edge strobes are registered: SW_RISE[i]/SW_FALL[i] are high for exactly the one cycle after the edge on which SW_DB[i] toggles, i.e. aligned with the new SW_DB value. SW_CHG = OR of all rise/fall strobes, same cycle.
- Reset mid-count: counters are discarded. After release, a switch held high yields SW_DB=1 after 2+DB_CYCLES edges, and SW_RISE pulses once then.
- Counter arithmetic: unsigned CNT_W bits; it never wraps because it reloads at DB_CYCLES-1.

Optional Feature:
- Macro: SW_EDGE_EN.
- Defined: SW_RISE, SW_FALL and SW_CHG are generated as described above.
- Undefined:
  - the edge logic is not built;
  - SW_RISE, SW_FALL and SW_CHG remain as ports, tied constant 0;
  - SW_DB behaviour is identical.

Test Plan (DB_CYCLES=4, WIDTH=5):
- Reset, SW=5'b00000 for 20 cycles -> SW_DB=0, no strobes, counters 0.
- SW 0->5'b00001 held -> SW_DB[0]=1 exactly 6 edges after the SW change. SW_RISE[0] and SW_CHG high for that one cycle only.
- SW[1] bounce 1,0,1,0,1 toggling every cycle, then held 1 -> SW_DB[1] stays 0 during the bounce. It rises 6 edges after the final transition, with a single SW_RISE[1] pulse.
- SW[2] pulses high for 3 cycles (< DB_CYCLES) -> SW_DB[2] stays 0; no strobes.
- SW=5'b11111 from 5'b00000 in one cycle -> all SW_DB bits rise on the same edge; SW_RISE=5'b11111; single SW_CHG pulse. Then SW=0 -> SW_FALL=5'b11111 6 edges later.
- SW[3]=1 with RST asserted at counter value 2 for 3 cycles, then released -> SW_DB stays 0 during reset. SW_DB[3]=1 6 edges after release.
- Build without SW_EDGE_EN -> repeat scenario 2: SW_DB timing unchanged; SW_RISE, SW_FALL and SW_CHG constantly 0.

Source files
------------

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: 2-flop synchronizer plus per-channel stability counter FSM.
// Optional registered edge strobes are built only when SW_EDGE_EN is defined.
module sw_debounce #(
  parameter int WIDTH     = 5,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             SW_CHG
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // The counter reloads on reaching this value, so it never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] w_db_nxt;
  state_t           r_state     [WIDTH];
  state_t           w_state_nxt [WIDTH];
  logic [CNT_W-1:0] r_cnt       [WIDTH];
  logic [CNT_W-1:0] w_cnt_nxt   [WIDTH];

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= SW;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_db <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_db <= w_db_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Any return of s2 to the accepted level while pending discards the count.
  always_comb begin
    w_db_nxt = r_db;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
    end
    for (int i = 0; i < WIDTH; i++) begin
      case (r_state[i])
        IDLE: begin
          if (r_s2[i] != r_db[i]) begin
            w_state_nxt[i] = PEND;
            w_cnt_nxt[i]   = CNT_W'(1);
          end else begin
            w_cnt_nxt[i]   = '0;
          end
        end
        PEND: begin
          if (r_s2[i] != r_db[i]) begin
            if (r_cnt[i] == CNT_LAST) begin
              w_db_nxt[i]    = r_s2[i];
              w_cnt_nxt[i]   = '0;
              w_state_nxt[i] = IDLE;
            end else begin
              w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(1);
            end
          end else begin
            w_cnt_nxt[i]   = '0;
            w_state_nxt[i] = IDLE;
          end
        end
        default: begin
          w_cnt_nxt[i]   = '0;
          w_state_nxt[i] = IDLE;
        end
      endcase
    end
  end

  assign SW_DB = r_db;

`ifdef SW_EDGE_EN
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_chg;

  // Strobes are registered from the next debounced value so they line up with the new SW_DB.
  assign w_rise = w_db_nxt & ~r_db;
  assign w_fall = ~w_db_nxt & r_db;

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_rise <= '0;
      r_fall <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_chg  <= |(w_rise | w_fall);
    end
  end

  assign SW_RISE = r_rise;
  assign SW_FALL = r_fall;
  assign SW_CHG  = r_chg;
`else
  assign SW_RISE = '0;
  assign SW_FALL = '0;
  assign SW_CHG  = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed and randomized bench for sw_debounce; reference model works from a history of
// applied switch samples rather than from a counter state machine.
module tb_sw_debounce;

  localparam int W  = 5;
  localparam int DB = 4;

  logic         CLK100MHZ = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] SW = '0;
  logic [W-1:0] SW_DB;
  logic [W-1:0] SW_RISE;
  logic [W-1:0] SW_FALL;
  logic         SW_CHG;

  int vectors = 0;
  int miscompares = 0;

  sw_debounce #(.WIDTH(W), .DB_CYCLES(DB), .CNT_W(20)) dut (
    .CLK100MHZ(CLK100MHZ),
    .RST(RST),
    .SW(SW),
    .SW_DB(SW_DB),
    .SW_RISE(SW_RISE),
    .SW_FALL(SW_FALL),
    .SW_CHG(SW_CHG)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Reference: SW value captured at each edge; s2 seen at edge n is the sample of edge n-2.
  logic [W-1:0] hist_q[$];
  logic [W-1:0] m_db;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  task automatic model_reset();
    hist_q.delete();
    for (int i = 0; i < DB + 2; i++) hist_q.push_back('0);
    m_db   = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  // A bit flips once the last DB synchronized samples all differ from the accepted level.
  task automatic model_edge();
    logic [W-1:0] nxt;
    bit           all_diff;
    int           n;
    if (RST) begin
      model_reset();
    end else begin
      nxt = m_db;
      n   = hist_q.size();
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
          if (hist_q[n-2-j][b] == m_db[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~m_db[b];
      end
      m_rise = nxt & ~m_db;
      m_fall = ~nxt & m_db;
      m_db   = nxt;
      hist_q.push_back(SW);
      while (hist_q.size() > DB + 2) void'(hist_q.pop_front());
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check_vec("sw_db", SW_DB, m_db);
`ifdef SW_EDGE_EN
    check_vec("sw_rise", SW_RISE, m_rise);
    check_vec("sw_fall", SW_FALL, m_fall);
    check_vec("sw_chg", {4'b0, SW_CHG}, {4'b0, |(m_rise | m_fall)});
`else
    check_vec("sw_rise_tied", SW_RISE, '0);
    check_vec("sw_fall_tied", SW_FALL, '0);
    check_vec("sw_chg_tied", {4'b0, SW_CHG}, '0);
`endif
  endtask

  // One clock: model update at the edge, check 1 ns later, return at the falling edge.
  task automatic step();
    @(posedge CLK100MHZ);
    model_edge();
    #1;
    check_outputs();
    @(negedge CLK100MHZ);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Count edges until the masked SW_DB bits reach lvl (bounded).
  task automatic latency(input string tag, input logic [W-1:0] mask,
                         input logic [W-1:0] lvl, input int exp_n);
    int n = 0;
    bit hit = 1'b0;
    while (n < 40 && !hit) begin
      step();
      n++;
      if ((SW_DB & mask) === (lvl & mask)) hit = 1'b1;
    end
    check_int(tag, n, exp_n);
  endtask

  initial begin
    int hold;
    logic [W-1:0] flip;
    model_reset();
    #1 RST = 1'b1;
    #1 check_outputs();
    steps(3);
    RST = 1'b0;
    SW  = '0;
    steps(20);
    check_vec("idle_db", SW_DB, '0);

    SW = 5'b00001;
    latency("lat_single", 5'b00001, 5'b00001, 6);
    steps(3);
    SW = '0;
    steps(10);

    SW = 5'b00010; step();
    SW = 5'b00000; step();
    SW = 5'b00010; step();
    SW = 5'b00000; step();
    SW = 5'b00010;
    latency("lat_bounce", 5'b00010, 5'b00010, 6);
    SW = '0;
    steps(10);

    SW = 5'b00100;
    steps(3);
    SW = '0;
    steps(12);
    check_vec("glitch_db", SW_DB, '0);

    SW = 5'b11111;
    latency("lat_all_rise", 5'b11111, 5'b11111, 6);
    steps(3);
    SW = 5'b00000;
    latency("lat_all_fall", 5'b11111, 5'b00000, 6);
    steps(5);

    SW = 5'b01000;
    steps(4);
    RST = 1'b1;
    model_reset();
    #1 check_outputs();
    @(negedge CLK100MHZ);
    steps(3);
    RST = 1'b0;
    latency("lat_after_reset", 5'b01000, 5'b01000, 6);
    SW = '0;
    steps(10);

    for (int it = 0; it < 300; it++) begin
      flip = W'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) flip = '0;
      SW   = SW ^ flip;
      hold = $urandom_range(1, 7);
      steps(hold);
    end
    SW = '0;
    steps(12);
    check_vec("final_db", SW_DB, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
